// File: rtl/mem_access_unit.sv
// Memory-side stage: decodes mem_ctrl/ir_ld, drives the synchronous IRAM/DRAM and holds PC, MAR, IR and MBR.
// Optional access counters (n_ifetch/n_dread/n_dwrite) are built when MEM_STATS_EN is defined.
module mem_access_unit #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int IADDR_W = 8,
    parameter int IW      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         mem_ctrl,
    input  logic               ir_ld,
    input  logic               mar_ld,
    input  logic               pc_ld,
    input  logic [ADDR_W-1:0]  bus_in,
    input  logic [DATA_W-1:0]  ac_in,
    output logic               iram_en,
    output logic [IADDR_W-1:0] iram_addr,
    input  logic [IW-1:0]      iram_rdata,
    output logic               dram_en,
    output logic               dram_we,
    output logic [ADDR_W-1:0]  dram_addr,
    output logic [DATA_W-1:0]  dram_wdata,
    input  logic [DATA_W-1:0]  dram_rdata,
    output logic [5:0]         MBRU,
    output logic [DATA_W-1:0]  mbr,
    output logic [IADDR_W-1:0] pc,
    output logic [IW-1:0]      ir,
    output logic               illegal
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]        n_ifetch,
    output logic [15:0]        n_dread,
    output logic [15:0]        n_dwrite
`endif
);

    logic [IADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0]  mar_q, mar_d;
    logic [IW-1:0]      ir_q, ir_d;
    logic [DATA_W-1:0]  mbr_q, mbr_d;
    logic               rd_pend_q, rd_pend_d;
    logic               illegal_q, illegal_d;

    logic is_fetch, is_read, is_write, is_bad;

    assign is_fetch = (mem_ctrl == 3'b100);
    assign is_read  = (mem_ctrl == 3'b010);
    assign is_write = (mem_ctrl == 3'b001);
    assign is_bad   = (mem_ctrl[0] & mem_ctrl[1]) | (mem_ctrl[0] & mem_ctrl[2]) |
                      (mem_ctrl[1] & mem_ctrl[2]);

    // Strobes are masked by rst so an access in flight drops the moment reset arrives.
    assign iram_en    = ~rst & is_fetch;
    assign iram_addr  = pc_q;
    assign dram_en    = ~rst & (is_read | is_write);
    assign dram_we    = ~rst & is_write;
    assign dram_addr  = mar_q;
    assign dram_wdata = ac_in;

    assign MBRU    = rst ? 6'd0 : (ir_ld ? iram_rdata[IW-1:IW-6] : ir_q[IW-1:IW-6]);
    assign mbr     = rd_pend_q ? dram_rdata : mbr_q;
    assign pc      = pc_q;
    assign ir      = ir_q;
    assign illegal = illegal_q;

    always_comb begin
        pc_d      = pc_q;
        mar_d     = mar_q;
        ir_d      = ir_q;
        mbr_d     = mbr_q;
        rd_pend_d = is_read;
        illegal_d = illegal_q | is_bad;
        if (pc_ld) begin
            pc_d = bus_in[IADDR_W-1:0];
        end else if (is_fetch) begin
            pc_d = pc_q + 1'b1;
        end
        if (mar_ld) begin
            mar_d = bus_in;
        end
        if (ir_ld) begin
            ir_d = iram_rdata;
        end
        // A write issued in the same cycle as returning read data is the newer value.
        if (is_write) begin
            mbr_d = ac_in;
        end else if (rd_pend_q) begin
            mbr_d = dram_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            mar_q     <= '0;
            ir_q      <= '0;
            mbr_q     <= '0;
            rd_pend_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            mar_q     <= mar_d;
            ir_q      <= ir_d;
            mbr_q     <= mbr_d;
            rd_pend_q <= rd_pend_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef MEM_STATS_EN
    logic [15:0] n_ifetch_q, n_dread_q, n_dwrite_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_ifetch_q <= '0;
            n_dread_q  <= '0;
            n_dwrite_q <= '0;
        end else begin
            if (is_fetch && n_ifetch_q != 16'hFFFF) n_ifetch_q <= n_ifetch_q + 16'd1;
            if (is_read  && n_dread_q  != 16'hFFFF) n_dread_q  <= n_dread_q + 16'd1;
            if (is_write && n_dwrite_q != 16'hFFFF) n_dwrite_q <= n_dwrite_q + 16'd1;
        end
    end

    assign n_ifetch = n_ifetch_q;
    assign n_dread  = n_dread_q;
    assign n_dwrite = n_dwrite_q;
`endif

endmodule
